// File: rtl/log10_arb_pkg.sv
// Shared types and constants for the log10 request arbiter.
package log10_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] NUMBER_ONE  = 32'h0001_0000;
  localparam logic [31:0] LOG_ERR_VAL = 32'hFFFF_FFFF;
  localparam int          TMO_DEFAULT = 1023;

endpackage

// File: rtl/log10_arbiter_rr_picker.sv
// Combinational round-robin select: first set req bit at or after ptr, wrapping.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      j = sum[IW-1:0];
      if (req[j]) begin
        win    = '0;
        win[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/log10_arbiter.sv
// Round-robin front end sharing one log10 engine between NREQ requesters.
// Build option LOG10_ARB_GUARD_EN rejects zero/negative operands without using the engine.
module log10_arbiter
  import log10_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N    = 32,
  parameter int Q    = 16,
  parameter int TMO  = TMO_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] x_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   vld,
  output logic [N-1:0]      y_out,
  output logic              err,
  output logic              busy,
  output logic              log_start,
  output logic [N-1:0]      log_x,
  input  logic [N-1:0]      log_y,
  input  logic              log_done
);

  localparam int IW   = $clog2(NREQ);
  localparam int WD_W = $clog2(TMO + 1);

  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("log10_arbiter: NREQ must be 2..8");
  end
  if (Q >= N - 1) begin : g_chk_q
    $error("log10_arbiter: Q must leave room for sign and integer bits");
  end

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   idx;
  logic [WD_W-1:0] wd;

  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [N-1:0]    x_sel;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_idx == IW'(i)) x_sel = x_in[i*N +: N];
  end

  assign busy = (state != IDLE);

`ifdef LOG10_ARB_GUARD_EN
  logic bad;
  logic bad_now;
  assign bad_now = (x_sel[N-2:0] == '0) || x_sel[N-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      wd        <= '0;
      gnt       <= '0;
      vld       <= '0;
      err       <= 1'b0;
      log_start <= 1'b0;
      y_out     <= '0;
      log_x     <= '0;
`ifdef LOG10_ARB_GUARD_EN
      bad       <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      vld       <= '0;
      log_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            log_x <= x_sel;
            idx   <= pick_idx;
            gnt   <= pick_win;
            wd    <= '0;
            state <= ISSUE;
`ifdef LOG10_ARB_GUARD_EN
            bad       <= bad_now;
            log_start <= ~bad_now;
`else
            log_start <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          // wd counts cycles since log_start was raised.
          wd <= wd + 1'b1;
`ifdef LOG10_ARB_GUARD_EN
          if (bad) begin
            y_out <= N'(LOG_ERR_VAL);
            err   <= 1'b1;
            state <= RESP;
          end else begin
            state <= WAIT;
          end
`else
          state <= WAIT;
`endif
        end
        WAIT: begin
          if (log_done) begin
            y_out <= log_y;
            err   <= 1'b0;
            state <= RESP;
          end else if (wd + 1'b1 == WD_W'(TMO)) begin
            y_out <= N'(LOG_ERR_VAL);
            err   <= 1'b1;
            state <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          vld   <= NREQ'(1) << idx;
          ptr   <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log10_arbiter.sv
// Directed bench for log10_arbiter with a fixed-latency engine stub (hang/stray controls).
module tb_log10_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] x_in;
  logic [NREQ-1:0]   gnt, vld;
  logic [N-1:0]      y_out, log_x, log_y;
  logic              err, busy, log_start, log_done;

  logic [3:0]  cnt;
  logic [31:0] cap;
  logic        hang, stray;
  int          ls_cnt;
  int          errors, checks;

  always #5 clk = ~clk;

  log10_arbiter #(.NREQ(NREQ), .N(N), .Q(16), .TMO(15)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt), .vld(vld),
    .y_out(y_out), .err(err), .busy(busy), .log_start(log_start),
    .log_x(log_x), .log_y(log_y), .log_done(log_done)
  );

  function automatic logic [31:0] ref_log(input logic [31:0] x);
    case (x)
      32'h0001_0000: ref_log = 32'h0000_0000;
      32'h000A_0000: ref_log = 32'h0001_0000;
      32'h0064_0000: ref_log = 32'h0002_0000;
      32'h03E8_0000: ref_log = 32'h0003_0000;
      default:       ref_log = 32'h1234_5678;
    endcase
  endfunction

  // Engine stub: done LAT cycles after the log_start cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      cap <= '0;
    end else if (log_start) begin
      cnt <= 4'(LAT);
      cap <= log_x;
    end else if (cnt != 0) begin
      cnt <= cnt - 1'b1;
    end
  end
  assign log_done = (!hang && cnt == 4'd1) || stray;
  assign log_y    = ref_log(cap);

  always @(posedge clk) if (log_start) ls_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_vld(input string tag, output int cyc);
    cyc = 0;
    while (vld == '0 && cyc < 100) begin
      step();
      cyc++;
    end
    if (vld == '0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no vld expected vld within 100 cycles", tag);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int c;
    c = 0;
    while (gnt == '0 && c < 100) begin
      step();
      c++;
    end
    if (gnt == '0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no gnt expected gnt within 100 cycles", tag);
    end
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    x_in[i*N +: N] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int cyc, ls0, nv;
    errors = 0; checks = 0; ls_cnt = 0;
    req = '0; x_in = '0; hang = 1'b0; stray = 1'b0;
    do_reset();

    // reset state
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_start", 32'(log_start), 0);
    chk("rst_y", y_out, 0);
    chk("rst_logx", log_x, 0);

    // single request, log10(1.0) = 0
    req = 4'b0001; set_x(0, 32'h0001_0000);
    step();
    chk("s0_gnt", 32'(gnt), 32'b0001);
    chk("s0_start", 32'(log_start), 1);
    chk("s0_logx", log_x, 32'h0001_0000);
    chk("s0_busy", 32'(busy), 1);
    req = '0; set_x(0, 32'hDEAD_BEEF);
    wait_vld("s0_wait", cyc);
    chk("s0_lat", 32'(cyc), 5);
    chk("s0_vld", 32'(vld), 32'b0001);
    chk("s0_y", y_out, 32'h0000_0000);
    chk("s0_err", 32'(err), 0);
    chk("s0_logx_hold", log_x, 32'h0001_0000);
    chk("s0_idle", 32'(busy), 0);

    // single request on lane 2, log10(10.0) ~= 1.0
    req = 4'b0100; set_x(2, 32'h000A_0000);
    step();
    chk("s2_gnt", 32'(gnt), 32'b0100);
    req = '0;
    wait_vld("s2_wait", cyc);
    chk("s2_vld", 32'(vld), 32'b0100);
    chk("s2_y_range", 32'((y_out >= 32'h0000_FF00) && (y_out <= 32'h0001_0100)), 1);
    chk("s2_err", 32'(err), 0);

    // watchdog: engine never answers, TMO = 15
    hang = 1'b1;
    req = 4'b1000; set_x(3, 32'h0001_0000);
    step();
    chk("wd_gnt", 32'(gnt), 32'b1000);
    chk("wd_start", 32'(log_start), 1);
    req = '0;
    wait_vld("wd_wait", cyc);
    chk("wd_lat", 32'(cyc), 16);
    chk("wd_vld", 32'(vld), 32'b1000);
    chk("wd_y", y_out, 32'hFFFF_FFFF);
    chk("wd_err", 32'(err), 1);
    chk("wd_idle", 32'(busy), 0);
    hang = 1'b0;
    req = 4'b0001; set_x(0, 32'h000A_0000);
    step();
    chk("wd_next_gnt", 32'(gnt), 32'b0001);
    req = '0;
    wait_vld("wd_next_wait", cyc);
    chk("wd_next_lat", 32'(cyc), 5);
    chk("wd_next_y", y_out, 32'h0001_0000);
    chk("wd_next_err", 32'(err), 0);

    // stray log_done while idle is ignored
    step();
    stray = 1'b1; step(); stray = 1'b0; step();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_vld", 32'(vld), 0);
    chk("stray_y", y_out, 32'h0001_0000);

    // round robin with all requests held
    do_reset();
    set_x(0, 32'h0001_0000); set_x(1, 32'h000A_0000);
    set_x(2, 32'h0064_0000); set_x(3, 32'h03E8_0000);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      wait_gnt("rr_gnt_wait");
      g = gnt;
      chk("rr_gnt", 32'(g), 32'(4'b0001 << (k % 4)));
      wait_vld("rr_vld_wait", cyc);
      chk("rr_vld", 32'(vld), 32'(g));
      chk("rr_y", y_out, ref_log(32'h0001_0000 * (k % 4 == 0 ? 1 : k % 4 == 1 ? 10 : k % 4 == 2 ? 100 : 1000)));
    end
    req = '0;

    // reset during WAIT drops the request
    step();
    req = 4'b0010; set_x(1, 32'h0064_0000);
    step();
    chk("rm_gnt", 32'(gnt), 32'b0010);
    req = '0;
    step();
    chk("rm_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("rm_busy0", 32'(busy), 0);
    chk("rm_start0", 32'(log_start), 0);
    chk("rm_y0", y_out, 0);
    chk("rm_logx0", log_x, 0);
    chk("rm_err0", 32'(err), 0);
    step(); step();
    rst = 1'b1;
    nv = 0;
    repeat (10) begin
      step();
      if (vld != '0) nv++;
    end
    chk("rm_no_vld", 32'(nv), 0);

`ifdef LOG10_ARB_GUARD_EN
    // guarded operands never reach the engine
    ls0 = ls_cnt;
    req = 4'b0010; set_x(1, 32'h0000_0000);
    step();
    chk("g0_gnt", 32'(gnt), 32'b0010);
    req = '0;
    wait_vld("g0_wait", cyc);
    chk("g0_lat", 32'(cyc), 2);
    chk("g0_vld", 32'(vld), 32'b0010);
    chk("g0_y", y_out, 32'hFFFF_FFFF);
    chk("g0_err", 32'(err), 1);
    step();
    req = 4'b0010; set_x(1, 32'h8001_0000);
    step();
    chk("gn_gnt", 32'(gnt), 32'b0010);
    req = '0;
    wait_vld("gn_wait", cyc);
    chk("gn_lat", 32'(cyc), 2);
    chk("gn_y", y_out, 32'hFFFF_FFFF);
    chk("gn_err", 32'(err), 1);
    chk("g_no_start", 32'(ls_cnt - ls0), 0);
`else
    // without the guard a zero operand is sent to the engine
    ls0 = ls_cnt;
    req = 4'b0010; set_x(1, 32'h0000_0000);
    step();
    chk("ng_gnt", 32'(gnt), 32'b0010);
    chk("ng_start", 32'(log_start), 1);
    req = '0;
    wait_vld("ng_wait", cyc);
    chk("ng_lat", 32'(cyc), 5);
    chk("ng_y", y_out, 32'h1234_5678);
    chk("ng_starts", 32'(ls_cnt - ls0), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
